// File: rtl/acc_snapshot_serializer.sv
// acc_snapshot_serializer: snapshots the accumulator bus on a request and
// shifts it out MSB first as a framed serial stream (ser_clk/ser_data/ser_frame).
// Requests come from a synchronized external pin or a free-running period counter.
// Optional build macro ACC_PARITY_EN appends an even-parity bit after the payload.
module acc_snapshot_serializer #(
  parameter int ACC_WIDTH   = 24,
  parameter int DIV_HALF    = 2,
  parameter int GAP_CYCLES  = 8,
  parameter int AUTO_PERIOD = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_WIDTH-1:0] data_in,
  input  logic                 trig_in,
  input  logic                 auto_en,
  output logic                 ser_clk,
  output logic                 ser_data,
  output logic                 ser_frame,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IDX_W  = (ACC_WIDTH  > 1) ? $clog2(ACC_WIDTH)  : 1;
  localparam int DIV_W  = (DIV_HALF   > 1) ? $clog2(DIV_HALF)   : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(ACC_WIDTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_HALF - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

`ifdef ACC_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] shadow, shadow_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt, bit_idx_dec;
  logic [DIV_W-1:0]     div_cnt, div_cnt_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
  logic [AUTO_W-1:0]    auto_cnt;
  logic                 ser_clk_nxt, ser_data_nxt, ser_frame_nxt;
  logic                 busy_nxt, done_nxt, overrun_nxt;
  logic                 trig_meta, trig_sync, trig_prev;
  logic                 trig_req, auto_req, req, enter_gap;

  // Two-flop synchronizer plus a delay flop for rising-edge detection of trig_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_meta <= trig_in;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
    end
  end

  assign trig_req = trig_sync & ~trig_prev;

  // Free-running period counter for automatic requests, parked at 0 when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!auto_en || auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  assign auto_req = auto_en && (auto_cnt == AUTO_LAST);
  assign req      = trig_req | auto_req;

  // State register and registered serial outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shadow    <= '0;
      bit_idx   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      ser_clk   <= 1'b0;
      ser_data  <= 1'b0;
      ser_frame <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      bit_idx   <= bit_idx_nxt;
      div_cnt   <= div_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      ser_clk   <= ser_clk_nxt;
      ser_data  <= ser_data_nxt;
      ser_frame <= ser_frame_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Next-state and output decode; each bit is DIV_HALF low cycles then DIV_HALF high cycles
  always_comb begin
    state_nxt     = state;
    shadow_nxt    = shadow;
    bit_idx_nxt   = bit_idx;
    div_cnt_nxt   = div_cnt;
    gap_cnt_nxt   = gap_cnt;
    ser_clk_nxt   = ser_clk;
    ser_data_nxt  = ser_data;
    ser_frame_nxt = ser_frame;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    overrun_nxt   = overrun | (req && state != S_IDLE);
    enter_gap     = 1'b0;
    bit_idx_dec   = bit_idx - IDX_W'(1);

    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt     = S_SHIFT;
          shadow_nxt    = data_in;
          ser_frame_nxt = 1'b1;
          busy_nxt      = 1'b1;
          ser_clk_nxt   = 1'b0;
          ser_data_nxt  = data_in[ACC_WIDTH-1];
          bit_idx_nxt   = IDX_FIRST;
          div_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (!ser_clk) begin
            ser_clk_nxt = 1'b1;
          end else if (bit_idx == '0) begin
`ifdef ACC_PARITY_EN
            state_nxt    = S_PAR;
            ser_clk_nxt  = 1'b0;
            ser_data_nxt = ^shadow;
`else
            enter_gap = 1'b1;
`endif
          end else begin
            bit_idx_nxt  = bit_idx_dec;
            ser_clk_nxt  = 1'b0;
            ser_data_nxt = shadow[bit_idx_dec];
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
`ifdef ACC_PARITY_EN
      S_PAR: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (!ser_clk) begin
            ser_clk_nxt = 1'b1;
          end else begin
            enter_gap = 1'b1;
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = S_IDLE;
          busy_nxt    = 1'b0;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (enter_gap) begin
      state_nxt     = S_GAP;
      ser_frame_nxt = 1'b0;
      ser_clk_nxt   = 1'b0;
      ser_data_nxt  = 1'b0;
      done_nxt      = 1'b1;
      gap_cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_acc_snapshot_serializer.sv
// tb_acc_snapshot_serializer: directed bench for acc_snapshot_serializer.
// Adapts frame length expectations when ACC_PARITY_EN is defined.
module tb_acc_snapshot_serializer;

  localparam int ACC_WIDTH = 24;
  localparam int DIV_HALF  = 2;
  localparam int GAP       = 8;
`ifdef ACC_PARITY_EN
  localparam int FRAME_BITS = ACC_WIDTH + 1;
`else
  localparam int FRAME_BITS = ACC_WIDTH;
`endif
  localparam int FRAME_CYC = FRAME_BITS * 2 * DIV_HALF;

  logic                 clk;
  logic                 rst_n;
  logic [ACC_WIDTH-1:0] data_in;
  logic                 trig_in;
  logic                 auto_en;
  logic                 ser_clk, ser_data, ser_frame, busy, done, overrun;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rx_word = '0;
  int          rx_count = 0;
  int          frame_cycles = 0;
  int          busy_cycles = 0;
  int          done_count = 0;

  acc_snapshot_serializer #(
    .ACC_WIDTH(ACC_WIDTH),
    .DIV_HALF(DIV_HALF),
    .GAP_CYCLES(GAP),
    .AUTO_PERIOD(200)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .trig_in(trig_in),
    .auto_en(auto_en),
    .ser_clk(ser_clk),
    .ser_data(ser_data),
    .ser_frame(ser_frame),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver: shift in ser_data on each ser_clk rising edge inside a frame
  always @(posedge ser_clk) begin
    if (ser_frame) begin
      rx_word  <= {rx_word[30:0], ser_data};
      rx_count <= rx_count + 1;
    end
  end

  // Running totals of frame, busy and done cycles
  always @(posedge clk) begin
    if (ser_frame) frame_cycles <= frame_cycles + 1;
    if (busy)      busy_cycles  <= busy_cycles + 1;
    if (done)      done_count   <= done_count + 1;
  end

  function automatic logic [23:0] payload();
    return rx_word[FRAME_BITS-1 -: 24];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise trig_in with the given data, hold it for 'hold' cycles, then release
  task automatic applyStimulus(input logic [23:0] word, input int hold);
    data_in = word;
    trig_in = 1'b1;
    waitCycles(hold);
    trig_in = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
  endtask

  initial begin
    int rx0, fc0, bc0, dc0;
    int starts[4];
    logic [23:0] words[4];
    int n_start, n_word;
    logic prev_frame;

    rst_n   = 1'b0;
    data_in = '0;
    trig_in = 1'b0;
    auto_en = 1'b0;
    waitCycles(3);
    checkOutput("rst_ser_clk",   32'(ser_clk),   32'd0);
    checkOutput("rst_ser_data",  32'(ser_data),  32'd0);
    checkOutput("rst_ser_frame", 32'(ser_frame), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_overrun",   32'(overrun),   32'd0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] single trigger");
    rx0 = rx_count; fc0 = frame_cycles; bc0 = busy_cycles; dc0 = done_count;
    data_in = 24'hA5C3F0;
    trig_in = 1'b1;
    waitCycles(2);
    checkOutput("lat_edge2_frame", 32'(ser_frame), 32'd0);
    waitCycles(1);
    checkOutput("lat_edge3_frame", 32'(ser_frame), 32'd1);
    checkOutput("t0_busy",         32'(busy),      32'd1);
    checkOutput("t0_ser_clk",      32'(ser_clk),   32'd0);
    checkOutput("t0_msb",          32'(ser_data),  32'd1);
    waitCycles(2);
    trig_in = 1'b0;
    checkOutput("t2_ser_clk",      32'(ser_clk),   32'd1);
    waitCycles(2);
    checkOutput("t4_bit1",         32'(ser_data),  32'd0);
    checkOutput("t4_ser_clk",      32'(ser_clk),   32'd0);
    waitCycles(FRAME_CYC - 5);
    checkOutput("last_frame_hi",   32'(ser_frame), 32'd1);
    waitCycles(1);
    checkOutput("end_frame_lo",    32'(ser_frame), 32'd0);
    checkOutput("end_done",        32'(done),      32'd1);
    checkOutput("end_ser_data",    32'(ser_data),  32'd0);
    waitCycles(1);
    checkOutput("done_one_cycle",  32'(done),      32'd0);
    waitCycles(GAP - 2);
    checkOutput("gap_busy_hi",     32'(busy),      32'd1);
    waitCycles(1);
    checkOutput("gap_busy_lo",     32'(busy),      32'd0);
    checkOutput("s1_payload",      32'(payload()), 32'hA5C3F0);
    checkOutput("s1_bits",         32'(rx_count - rx0),     32'(FRAME_BITS));
    checkOutput("s1_frame_len",    32'(frame_cycles - fc0), 32'(FRAME_CYC));
    checkOutput("s1_busy_len",     32'(busy_cycles - bc0),  32'(FRAME_CYC + GAP));
    checkOutput("s1_done_count",   32'(done_count - dc0),   32'd1);
    checkOutput("s1_no_overrun",   32'(overrun),   32'd0);

    $display("[TB] snapshot isolation");
    waitCycles(2);
    rx0 = rx_count;
    applyStimulus(24'hA5C3F0, 3);
    waitCycles(22);
    data_in = 24'h000001;
    waitIdle("iso_idle");
    checkOutput("iso_payload", 32'(payload()), 32'hA5C3F0);
    checkOutput("iso_bits",    32'(rx_count - rx0), 32'(FRAME_BITS));

    $display("[TB] reset mid-frame");
    waitCycles(2);
    applyStimulus(24'hFFFFFF, 3);
    waitCycles(42);
    dc0 = done_count;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ser_clk",   32'(ser_clk),   32'd0);
    checkOutput("abort_ser_data",  32'(ser_data),  32'd0);
    checkOutput("abort_ser_frame", 32'(ser_frame), 32'd0);
    checkOutput("abort_busy",      32'(busy),      32'd0);
    checkOutput("abort_done",      32'(done),      32'd0);
    checkOutput("abort_overrun",   32'(overrun),   32'd0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("abort_no_done", 32'(done_count - dc0), 32'd0);
    rx0 = rx_count; fc0 = frame_cycles;
    applyStimulus(24'h5A3C0F, 3);
    waitIdle("post_abort_idle");
    checkOutput("post_abort_payload", 32'(payload()), 32'h5A3C0F);
    checkOutput("post_abort_bits",    32'(rx_count - rx0),     32'(FRAME_BITS));
    checkOutput("post_abort_len",     32'(frame_cycles - fc0), 32'(FRAME_CYC));

    $display("[TB] overrun during shift");
    waitCycles(2);
    dc0 = done_count;
    applyStimulus(24'h123456, 3);
    waitCycles(20);
    trig_in = 1'b1;
    waitCycles(4);
    checkOutput("ovr_shift_flag",  32'(overrun),   32'd1);
    checkOutput("ovr_frame_alive", 32'(ser_frame), 32'd1);
    trig_in = 1'b0;
    waitIdle("ovr_idle");
    checkOutput("ovr_payload",  32'(payload()), 32'h123456);
    checkOutput("ovr_sticky",   32'(overrun),   32'd1);
    checkOutput("ovr_one_done", 32'(done_count - dc0), 32'd1);

    $display("[TB] overrun during gap");
    pulseReset();
    checkOutput("ovr_cleared", 32'(overrun), 32'd0);
    dc0 = done_count;
    applyStimulus(24'h654321, 3);
    waitCycles(FRAME_CYC);
    trig_in = 1'b1;
    waitCycles(4);
    checkOutput("gap_ovr_flag", 32'(overrun), 32'd1);
    trig_in = 1'b0;
    waitCycles(10);
    checkOutput("gap_no_frame",    32'(busy),      32'd0);
    checkOutput("gap_done_count",  32'(done_count - dc0), 32'd1);
    checkOutput("gap_payload",     32'(payload()), 32'h654321);
    checkOutput("gap_ovr_sticky",  32'(overrun),   32'd1);

    $display("[TB] auto mode");
    pulseReset();
    n_start = 0; n_word = 0; prev_frame = 1'b0;
    data_in = 24'h000100;
    auto_en = 1'b1;
    for (int i = 0; i < 720; i++) begin
      @(negedge clk);
      if (ser_frame && !prev_frame) begin
        if (n_start < 4) starts[n_start] = i;
        n_start++;
      end
      if (done) begin
        if (n_word < 4) words[n_word] = payload();
        n_word++;
      end
      prev_frame = ser_frame;
      data_in = data_in + 24'd1;
    end
    auto_en = 1'b0;
    checkOutput("auto_starts",  32'(n_start), 32'd3);
    checkOutput("auto_words",   32'(n_word),  32'd3);
    if (n_start >= 3) begin
      checkOutput("auto_start0",   32'(starts[0]), 32'd199);
      checkOutput("auto_spacing",  32'(starts[1] - starts[0]), 32'd200);
      checkOutput("auto_start2",   32'(starts[2]), 32'd599);
    end
    if (n_word >= 3) begin
      checkOutput("auto_word0",    32'(words[0]), 32'h0001C7);
      checkOutput("auto_word_dif", 32'(words[1] - words[0]), 32'd200);
      checkOutput("auto_word2",    32'(words[2]), 32'h000357);
    end
    checkOutput("auto_no_overrun", 32'(overrun), 32'd0);
    waitIdle("auto_idle");

`ifdef ACC_PARITY_EN
    $display("[TB] parity");
    waitCycles(2);
    fc0 = frame_cycles;
    applyStimulus(24'h000007, 3);
    waitIdle("par7_idle");
    checkOutput("par7_payload", 32'(payload()), 32'h000007);
    checkOutput("par7_bit",     32'(rx_word[0]), 32'd1);
    checkOutput("par7_len",     32'(frame_cycles - fc0), 32'd100);
    waitCycles(2);
    applyStimulus(24'h000003, 3);
    waitIdle("par3_idle");
    checkOutput("par3_payload", 32'(payload()), 32'h000003);
    checkOutput("par3_bit",     32'(rx_word[0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
